// File: rtl/sockit_fifo.sv
// Single-clock valid/ready stream FIFO with arbitrary depth and an occupancy level output.
// Define SOCKIT_FIFO_BYP_EN to enable a combinational input-to-output path while empty.
module sockit_fifo #(
   parameter  int unsigned DW = 8,
   parameter  int unsigned FF = 4,
   localparam int unsigned CW = $clog2(FF + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [DW-1:0] ffi_bus,
   input  logic          ffi_vld,
   output logic          ffi_rdy,
   output logic [DW-1:0] ffo_bus,
   output logic          ffo_vld,
   input  logic          ffo_rdy,
   output logic [CW-1:0] ffo_lvl
);

   localparam int unsigned PW = (FF > 1) ? $clog2(FF) : 1;

   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          r_ffi_rdy;
   logic          r_ffo_vld;
   logic [DW-1:0] r_mem [FF];

   logic [PW-1:0] w_wp_nxt;
   logic [PW-1:0] w_rp_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_byp;
   logic          w_ffi_trn;
   logic          w_ffo_trn;
   logic          w_wr;
   logic          w_rd;

`ifdef SOCKIT_FIFO_BYP_EN
   // Gated by ffi_rdy so a word cannot reach the consumer without the producer's handshake.
   assign w_byp = (r_cnt == '0) & ~clr & r_ffi_rdy;
`else
   assign w_byp = 1'b0;
`endif

   assign ffi_rdy   = r_ffi_rdy;
   assign ffo_lvl   = r_cnt;
   assign ffo_vld   = w_byp ? ffi_vld : r_ffo_vld;
   assign ffo_bus   = w_byp ? ffi_bus : r_mem[r_rp];

   assign w_ffi_trn = ffi_vld & r_ffi_rdy;
   assign w_ffo_trn = ffo_vld & ffo_rdy;

   // A bypassed word taken by the consumer in the same cycle is never stored.
   assign w_wr      = w_ffi_trn & ~(w_byp & w_ffo_trn);
   assign w_rd      = w_ffo_trn & ~w_byp;

   assign w_wp_nxt  = (r_wp == PW'(FF - 1)) ? '0 : r_wp + PW'(1);
   assign w_rp_nxt  = (r_rp == PW'(FF - 1)) ? '0 : r_rp + PW'(1);

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_wr, w_rd})
         2'b10:   w_cnt_nxt = r_cnt + CW'(1);
         2'b01:   w_cnt_nxt = r_cnt - CW'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_cnt     <= '0;
         r_ffi_rdy <= 1'b0;
         r_ffo_vld <= 1'b0;
      end else if (clr) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_cnt     <= '0;
         r_ffi_rdy <= 1'b1;
         r_ffo_vld <= 1'b0;
      end else begin
         if (w_wr) r_wp <= w_wp_nxt;
         if (w_rd) r_rp <= w_rp_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ffi_rdy <= (w_cnt_nxt < CW'(FF));
         r_ffo_vld <= (w_cnt_nxt != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr & ~clr) r_mem[r_wp] <= ffi_bus;
   end

endmodule

// File: tb/tb_sockit_fifo.sv
// Self-checking bench for sockit_fifo (DW=8, FF=5) against a queue-based reference model.
module tb_sockit_fifo;

   localparam int unsigned DW = 8;
   localparam int unsigned FF = 5;
   localparam int unsigned CW = $clog2(FF + 1);
`ifdef SOCKIT_FIFO_BYP_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic [DW-1:0] ffi_bus;
   logic          ffi_vld;
   logic          ffi_rdy;
   logic [DW-1:0] ffo_bus;
   logic          ffo_vld;
   logic          ffo_rdy;
   logic [CW-1:0] ffo_lvl;

   sockit_fifo #(.DW(DW), .FF(FF)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .ffi_bus (ffi_bus),
      .ffi_vld (ffi_vld),
      .ffi_rdy (ffi_rdy),
      .ffo_bus (ffo_bus),
      .ffo_vld (ffo_vld),
      .ffo_rdy (ffo_rdy),
      .ffo_lvl (ffo_lvl)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model: contents as a queue, plus the expected input-ready flag.
   logic [DW-1:0] q[$];
   bit            m_rdy = 1'b0;
   bit            m_in_trn;
   bit            m_out_trn;
   int unsigned   max_lvl = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are set by the caller just after a falling edge; this checks outputs, then
   // advances the model across the next rising edge and returns at the following falling edge.
   task automatic cyc(input string tag);
      bit            byp;
      bit            exp_vld;
      logic [DW-1:0] exp_bus;
      #1;
      byp     = BYP && rst && (q.size() == 0) && !clr && m_rdy;
      exp_vld = byp ? ffi_vld : (rst && q.size() != 0);
      exp_bus = byp ? ffi_bus : ((q.size() != 0) ? q[0] : '0);
      check({tag, ".rdy"}, 32'(ffi_rdy), 32'(m_rdy));
      check({tag, ".vld"}, 32'(ffo_vld), 32'(exp_vld));
      check({tag, ".lvl"}, 32'(ffo_lvl), 32'(rst ? q.size() : 0));
      if (exp_vld) check({tag, ".bus"}, 32'(ffo_bus), 32'(exp_bus));
      if (32'(ffo_lvl) > max_lvl) max_lvl = 32'(ffo_lvl);
      m_in_trn  = ffi_vld && m_rdy && rst;
      m_out_trn = exp_vld && ffo_rdy;
      @(posedge clk);
      if (!rst) begin
         q.delete();
         m_rdy = 1'b0;
      end else if (clr) begin
         q.delete();
         m_rdy = 1'b1;
      end else begin
         if (!(byp && m_in_trn && m_out_trn)) begin
            if (m_out_trn) void'(q.pop_front());
            if (m_in_trn) q.push_back(ffi_bus);
         end
         m_rdy = (q.size() < FF);
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit vld, input logic [DW-1:0] dat, input bit ordy);
      ffi_vld = vld;
      ffi_bus = dat;
      ffo_rdy = ordy;
   endtask

   initial begin
      int unsigned wcnt;
      int unsigned rcnt;
      int unsigned budget;
      rst = 1'b0;
      clr = 1'b0;
      drive(1'b0, '0, 1'b0);
      @(negedge clk);

      // Reset held for three clocks, then the first edge raises ffi_rdy.
      for (int i = 0; i < 3; i++) cyc("reset");
      rst = 1'b1;
      cyc("rst_rel");
      cyc("rdy_up");

      // Fill to full with the consumer stalled, then try a sixth write.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, DW'(i), 1'b0);
         cyc("fill");
      end
      check("full_lvl", 32'(ffo_lvl), 32'(FF));
      drive(1'b1, 8'h05, 1'b1);
      cyc("full_rd");
      drive(1'b0, '0, 1'b1);
      for (int i = 0; i < 6; i++) cyc("drain");
      check("empty_vld", 32'(ffo_vld), 32'd0);

      // Steady state at three entries with a transfer on both ports every clock.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, DW'(8'h10 + i), 1'b0);
         cyc("pre3");
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, DW'(8'h20 + i), 1'b1);
         cyc("simul");
      end
      check("simul_lvl", 32'(ffo_lvl), 32'd3);

      // Clear at four entries while a write is offered: the word is dropped.
      drive(1'b1, 8'h3F, 1'b0);
      cyc("pre4");
      check("pre_clr_lvl", 32'(ffo_lvl), 32'd4);
      clr = 1'b1;
      drive(1'b1, 8'h77, 1'b0);
      cyc("clr");
      clr = 1'b0;
      drive(1'b0, '0, 1'b0);
      cyc("post_clr");
      drive(1'b1, 8'h5A, 1'b0);
      cyc("post_clr_wr");
      drive(1'b0, '0, 1'b1);
      cyc("post_clr_rd");
      cyc("post_clr_idle");

      // Empty FIFO, word offered with consumer ready.
      drive(1'b1, 8'hA5, 1'b1);
      cyc("byp");
      drive(1'b0, '0, 1'b1);
      cyc("byp_next");
      check("byp_lvl", 32'(ffo_lvl), 32'd0);
      cyc("byp_idle");

      // Random valid/ready with counter data; producer holds each word until accepted.
      wcnt = 0;
      rcnt = 0;
      budget = 0;
      ffi_vld = 1'b0;
      while (rcnt < 300 && budget < 4000) begin
         if (!ffi_vld) ffi_vld = ($urandom_range(1) == 1) && (wcnt < 300);
         ffi_bus = DW'(wcnt);
         ffo_rdy = ($urandom_range(1) == 1);
         if (ffo_vld && ffo_rdy) begin
            check("wrap_seq", 32'(ffo_bus), 32'(rcnt % 256));
            rcnt++;
         end
         if (ffi_vld && m_rdy) begin
            cyc("wrap");
            wcnt++;
            ffi_vld = 1'b0;
         end else begin
            cyc("wrap");
         end
         budget++;
      end
      check("wrap_done", rcnt, 32'd300);
      check("wrap_maxlvl", 32'(max_lvl <= FF), 32'd1);

      // Asynchronous reset with data stored.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, DW'(8'hC0 + i), 1'b0);
         cyc("pre_arst");
      end
      drive(1'b0, '0, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("arst_rdy", 32'(ffi_rdy), 32'd0);
      check("arst_vld", 32'(ffo_vld), 32'd0);
      check("arst_lvl", 32'(ffo_lvl), 32'd0);
      q.delete();
      m_rdy = 1'b0;
      @(negedge clk);
      cyc("in_arst");
      rst = 1'b1;
      cyc("arst_rel");
      drive(1'b1, 8'hE1, 1'b1);
      cyc("arst_wr");
      drive(1'b0, '0, 1'b1);
      cyc("arst_rd");
      cyc("arst_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sockit_fifo.md
# sockit_fifo

Single-clock stream FIFO, the parametrised successor of the sockit CDC FIFO for paths where both sides share one clock. Valid/ready handshake on both ports, arbitrary (non power-of-two) depth, occupancy level output and synchronous clear. Sits between stream producers and consumers inside one clock domain.

## Interface
- DW, 8, data width
- FF, 4, FIFO depth in entries, any integer >= 2
- CW, $clog2(FF+1), level width (derived, not overridden)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- clr  input  1  synchronous clear, active-high
- ffi_bus  input  DW  input data
- ffi_vld  input  1  input valid
- ffi_rdy  output  1  input ready
- ffo_bus  output  DW  output data
- ffo_vld  output  1  output valid
- ffo_rdy  input  1  output ready
- ffo_lvl  output  CW  number of stored entries, 0..FF

## Operation
- Transfers: ffi_trn = ffi_vld & ffi_rdy; ffo_trn = ffo_vld & ffo_rdy.
- State: write pointer wp, read pointer rp (0..FF-1), count cnt (0..FF), memory mem[FF] of DW bits; memory is not reset.
- Pointer wrap: pointer at FF-1 advances to 0; no power-of-two assumption.
- ffi_trn: mem[wp] <= ffi_bus, wp advances, cnt+1.
- ffo_trn: rp advances, cnt-1.
- Both in one cycle: both pointers advance, cnt unchanged.
- ffo_bus = mem[rp], asynchronous read; value undefined (X allowed) while ffo_vld=0.
- ffi_rdy, ffo_vld are registers: ffi_rdy <= (cnt_next < FF), ffo_vld <= (cnt_next != 0).
- ffo_lvl = cnt (registered).
- Full (cnt=FF): ffi_rdy=0 even if ffo_rdy=1 that cycle; no read-through-full.
- Empty (cnt=0): ffo_vld=0; an input accepted at edge k is visible at ffo after edge k.
- clr=1 at an edge: wp, rp, cnt <= 0, ffi_rdy <= 1, ffo_vld <= 0; overrides any transfer that cycle. A handshake completing on ffi during clr is dropped; a handshake completing on ffo during clr still counts as delivered to the consumer.
- Asynchronous reset mid-operation: all contents discarded, state as below.

## Timing
- Reset values (rst=0): ffi_rdy=0, ffo_vld=0, ffo_lvl=0, wp=rp=0.
- First rising edge after rst deasserts: ffi_rdy=1.
- Write-to-read latency: 1 clock (0 with bypass, see Configuration).
- Full throughput: one transfer per clock on each port simultaneously when 0<cnt<FF.
- No combinational path from ffo_rdy to ffi_rdy or from ffi_vld to ffo_vld (except bypass).
- Producer must hold ffi_bus and ffi_vld until ffi_trn; FIFO holds ffo_bus/ffo_vld stable until ffo_trn.

## Configuration
- SOCKIT_FIFO_BYP_EN defined: when cnt=0, ffi_vld drives ffo_vld and ffi_bus drives ffo_bus combinationally. With ffo_rdy=1 in the same cycle, data passes through and is not stored (cnt stays 0). With ffo_rdy=0, data is stored normally. ffi_rdy is unaffected. During clr, bypass is disabled (ffo_vld=0).
- Not defined: pure registered behaviour, 1-cycle minimum latency, no ffi-to-ffo combinational path.

## Test plan
- Reset: rst=0 for 3 clocks then 1 -> ffi_rdy=0, ffo_vld=0, ffo_lvl=0 during reset; ffi_rdy=1 after first edge.
- Fill/drain, DW=8, FF=5: write 0x00..0x04 with ffo_rdy=0 -> ffo_lvl=5, ffi_rdy=0; sixth write not accepted; drain -> data 0x00..0x04 in order, ffo_lvl=0, ffo_vld=0.
- Wrap-around, FF=5: 300 transfers, counter data, random vld/rdy at 50% -> output sequence equals counter mod 256, zero errors, ffo_lvl never exceeds 5.
- Simultaneous: hold cnt=3, ffi_vld=ffo_rdy=1 for 10 clocks -> ffo_lvl stays 3, outputs in order.
- Clear: cnt=4, assert clr for 1 clock with ffi_vld=1 -> ffo_lvl=0, ffo_vld=0, ffi_rdy=1 next cycle; the input word presented during clr is not stored.
- Bypass (SOCKIT_FIFO_BYP_EN): empty, ffi_vld=1, ffi_bus=0xA5, ffo_rdy=1 -> ffo_vld=1, ffo_bus=0xA5 same cycle, ffo_lvl stays 0; without macro -> ffo_vld=1 one cycle later, ffo_lvl=1.
